// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RISC-V instruction decode stage feeding a small in-order output queue
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int EN_FP = 0,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_instr,
    output logic [20:0]             out_op,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [2:0]              out_funct3,
    output logic [6:0]              out_funct7,
    output logic [XLEN-1:0]         out_imm,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);

    // out_op bit positions follow the base opcode map in ascending opcode order
    localparam int CLS_LOAD      = 0;
    localparam int CLS_LOAD_FP   = 1;
    localparam int CLS_MISC_MEM  = 2;
    localparam int CLS_OP_IMM    = 3;
    localparam int CLS_AUIPC     = 4;
    localparam int CLS_OP_IMM_32 = 5;
    localparam int CLS_STORE     = 6;
    localparam int CLS_STORE_FP  = 7;
    localparam int CLS_AMO       = 8;
    localparam int CLS_OP        = 9;
    localparam int CLS_LUI       = 10;
    localparam int CLS_OP_32     = 11;
    localparam int CLS_MADD      = 12;
    localparam int CLS_MSUB      = 13;
    localparam int CLS_NMSUB     = 14;
    localparam int CLS_NMADD     = 15;
    localparam int CLS_OP_FP     = 16;
    localparam int CLS_BRANCH    = 17;
    localparam int CLS_JALR      = 18;
    localparam int CLS_JAL       = 19;
    localparam int CLS_SYSTEM    = 20;

    localparam logic [20:0] FP_MASK = 21'h01F182;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [20:0]        dec_cls;
    logic [20:0]        dec_op;
    logic               dec_illegal;
    logic signed [31:0] dec_imm32;
    logic [XLEN-1:0]    dec_imm;

    always_comb begin
        dec_cls = '0;
        case (in_instr[6:2])
            5'b00000: dec_cls[CLS_LOAD]      = 1'b1;
            5'b00001: dec_cls[CLS_LOAD_FP]   = 1'b1;
            5'b00011: dec_cls[CLS_MISC_MEM]  = 1'b1;
            5'b00100: dec_cls[CLS_OP_IMM]    = 1'b1;
            5'b00101: dec_cls[CLS_AUIPC]     = 1'b1;
            5'b00110: dec_cls[CLS_OP_IMM_32] = 1'b1;
            5'b01000: dec_cls[CLS_STORE]     = 1'b1;
            5'b01001: dec_cls[CLS_STORE_FP]  = 1'b1;
            5'b01011: dec_cls[CLS_AMO]       = 1'b1;
            5'b01100: dec_cls[CLS_OP]        = 1'b1;
            5'b01101: dec_cls[CLS_LUI]       = 1'b1;
            5'b01110: dec_cls[CLS_OP_32]     = 1'b1;
            5'b10000: dec_cls[CLS_MADD]      = 1'b1;
            5'b10001: dec_cls[CLS_MSUB]      = 1'b1;
            5'b10010: dec_cls[CLS_NMSUB]     = 1'b1;
            5'b10011: dec_cls[CLS_NMADD]     = 1'b1;
            5'b10100: dec_cls[CLS_OP_FP]     = 1'b1;
            5'b11000: dec_cls[CLS_BRANCH]    = 1'b1;
            5'b11001: dec_cls[CLS_JALR]      = 1'b1;
            5'b11011: dec_cls[CLS_JAL]       = 1'b1;
            5'b11100: dec_cls[CLS_SYSTEM]    = 1'b1;
            default:  dec_cls = '0;
        endcase

        dec_illegal = (in_instr[1:0] != 2'b11) || (dec_cls == '0)
                   || ((XLEN == 32) && (dec_cls[CLS_OP_IMM_32] || dec_cls[CLS_OP_32]))
                   || ((EN_FP == 0) && ((dec_cls & FP_MASK) != '0));
        dec_op = dec_illegal ? '0 : dec_cls;

        // Illegal words have dec_op == 0, so they fall through to a zero immediate
        dec_imm32 = '0;
        if (dec_op[CLS_LOAD] || dec_op[CLS_OP_IMM] || dec_op[CLS_OP_IMM_32] || dec_op[CLS_JALR]
            || dec_op[CLS_SYSTEM] || dec_op[CLS_MISC_MEM] || dec_op[CLS_LOAD_FP])
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (dec_op[CLS_STORE] || dec_op[CLS_STORE_FP])
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (dec_op[CLS_BRANCH])
            dec_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        else if (dec_op[CLS_LUI] || dec_op[CLS_AUIPC])
            dec_imm32 = {in_instr[31:12], 12'b0};
        else if (dec_op[CLS_JAL])
            dec_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec_imm = XLEN'(dec_imm32);
    end

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [31:0]     q_instr [DEPTH];
    logic [20:0]     q_op    [DEPTH];
    logic [XLEN-1:0] q_imm   [DEPTH];
    logic            q_ill   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign out_valid = (count != '0);
    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_pc[wr_ptr]    <= in_pc;
            q_instr[wr_ptr] <= in_instr;
            q_op[wr_ptr]    <= dec_op;
            q_imm[wr_ptr]   <= dec_imm;
            q_ill[wr_ptr]   <= dec_illegal;
        end
    end

    // Payload is forced to zero whenever the queue is empty, including straight after reset
    assign out_pc      = out_valid ? q_pc[rd_ptr]    : '0;
    assign out_instr   = out_valid ? q_instr[rd_ptr] : '0;
    assign out_op      = out_valid ? q_op[rd_ptr]    : '0;
    assign out_imm     = out_valid ? q_imm[rd_ptr]   : '0;
    assign out_illegal = out_valid ? q_ill[rd_ptr]   : 1'b0;
    assign out_rd      = out_instr[11:7];
    assign out_rs1     = out_instr[19:15];
    assign out_rs2     = out_instr[24:20];
    assign out_funct3  = out_instr[14:12];
    assign out_funct7  = out_instr[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage, RV32 no-FP and RV64 FP configurations
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_pc, a_out_instr, a_out_imm;
    logic [20:0] a_out_op;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [2:0]  a_out_funct3;
    logic [6:0]  a_out_funct7;
    logic [1:0]  a_count;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_pc, b_out_imm;
    logic [31:0] b_out_instr;
    logic [20:0] b_out_op;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [2:0]  b_out_funct3;
    logic [6:0]  b_out_funct7;
    logic [1:0]  b_count;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_FP(0), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .out_instr(a_out_instr), .out_op(a_out_op), .out_rd(a_out_rd),
        .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_funct3(a_out_funct3),
        .out_funct7(a_out_funct7), .out_imm(a_out_imm), .out_illegal(a_out_illegal),
        .count(a_count));

    decode_stage #(.XLEN(64), .EN_FP(1), .DEPTH(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_instr(b_out_instr), .out_op(b_out_op), .out_rd(b_out_rd),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_funct3(b_out_funct3),
        .out_funct7(b_out_funct7), .out_imm(b_out_imm), .out_illegal(b_out_illegal),
        .count(b_count));

    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
        logic [20:0] op_a, op_b;
        logic [63:0] imm_a, imm_b;
        bit          ill_a, ill_b;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder, written from the opcode map table
    function automatic void model(input logic [31:0] w, input int xl, input bit fp,
                                  output logic [20:0] op, output logic [63:0] imm, output bit ill);
        int cls;
        logic [31:0] i32;
        case (w[6:2])
            5'h00: cls = 0;   5'h01: cls = 1;   5'h03: cls = 2;   5'h04: cls = 3;
            5'h05: cls = 4;   5'h06: cls = 5;   5'h08: cls = 6;   5'h09: cls = 7;
            5'h0B: cls = 8;   5'h0C: cls = 9;   5'h0D: cls = 10;  5'h0E: cls = 11;
            5'h10: cls = 12;  5'h11: cls = 13;  5'h12: cls = 14;  5'h13: cls = 15;
            5'h14: cls = 16;  5'h18: cls = 17;  5'h19: cls = 18;  5'h1B: cls = 19;
            5'h1C: cls = 20;  default: cls = -1;
        endcase
        ill = (w[1:0] != 2'b11) || (cls < 0) || (xl == 32 && (cls == 5 || cls == 11))
           || (!fp && (cls inside {1, 7, 8, 12, 13, 14, 15, 16}));
        case (cls)
            0, 1, 2, 3, 5, 18, 20: i32 = {{20{w[31]}}, w[31:20]};
            6, 7:                  i32 = {{20{w[31]}}, w[31:25], w[11:7]};
            17:                    i32 = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            4, 10:                 i32 = {w[31:12], 12'h000};
            19:                    i32 = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            default:               i32 = 32'h0;
        endcase
        imm = {{32{i32[31]}}, i32};
        if (xl == 32) imm[63:32] = 32'h0;
        op = '0;
        if (ill) imm = '0;
        else op[cls] = 1'b1;
    endfunction

    always @(negedge clk) begin
        sb_t e;
        int  n;
        if (rst) begin
            sb.delete();
        end else if (flush) begin
            check("in_ready_flush", a_in_ready, 0);
            check("b_in_ready_flush", b_in_ready, 0);
            sb.delete();
        end else begin
            n = sb.size();
            check("a_count", a_count, n);
            check("b_count", b_count, n);
            check("a_valid", a_out_valid, n != 0);
            check("b_valid", b_out_valid, n != 0);
            check("a_in_ready", a_in_ready, n < 2);
            check("b_in_ready", b_in_ready, n < 2);
            if (a_out_valid && n != 0) begin
                e = sb[0];
                check("a_pc", a_out_pc, e.pc[31:0]);
                check("a_instr", a_out_instr, e.w);
                check("a_rd", a_out_rd, e.w[11:7]);
                check("a_rs1", a_out_rs1, e.w[19:15]);
                check("a_rs2", a_out_rs2, e.w[24:20]);
                check("a_funct3", a_out_funct3, e.w[14:12]);
                check("a_funct7", a_out_funct7, e.w[31:25]);
                check("a_op", a_out_op, e.op_a);
                check("a_imm", a_out_imm, e.imm_a);
                check("a_illegal", a_out_illegal, e.ill_a);
                check("b_pc", b_out_pc, e.pc);
                check("b_instr", b_out_instr, e.w);
                check("b_rd", b_out_rd, e.w[11:7]);
                check("b_op", b_out_op, e.op_b);
                check("b_imm", b_out_imm, e.imm_b);
                check("b_illegal", b_out_illegal, e.ill_b);
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && n < 2) begin
                e.pc = in_pc;
                e.w  = in_instr;
                model(in_instr, 32, 1'b0, e.op_a, e.imm_a, e.ill_a);
                model(in_instr, 64, 1'b1, e.op_b, e.imm_b, e.ill_b);
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [63:0] pc);
        int n = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", a_in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (a_count != 0 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("drain_timeout", a_count, 0);
    endtask

    logic [31:0] words [19] = '{
        32'hFFF00093, 32'h0080006F, 32'h00000000, 32'h0000001B, 32'h12345037,
        32'hFE208EE3, 32'h00A12223, 32'h00008067, 32'h00000073, 32'h0FF0000F,
        32'h80002007, 32'h0000202F, 32'h00000053, 32'h0000003B, 32'h00000057,
        32'h00000092, 32'h80000017, 32'h8C000FA7, 32'hFFFFF043};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_count", a_count, 0);
        check("rst_valid", a_out_valid, 0);
        check("rst_pc", a_out_pc, 0);
        check("rst_instr", a_out_instr, 0);
        check("rst_op", a_out_op, 0);
        check("rst_imm", a_out_imm, 0);
        check("rst_b_imm", b_out_imm, 0);
        check("rst_in_ready", a_in_ready, 1);

        send(32'hFFF00093, 64'hA000_0000_0000_1000);
        check("latency_valid", a_out_valid, 1);
        check("latency_imm", a_out_imm, 32'hFFFF_FFFF);
        check("latency_b_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        for (int i = 0; i < 19; i++)
            send(words[i], {32'hB000_0000 + 32'(i), 32'h0000_2000 + 32'(i * 4)});
        drain();

        out_ready = 1'b0;
        send(32'h00100093, 64'h3000);
        send(32'h00200113, 64'h3004);
        check("bp_count", a_count, 2);
        check("bp_in_ready", a_in_ready, 0);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 64'h3008;
        step();
        check("bp_no_bypass", a_count, 2);
        out_ready = 1'b1;
        step();
        check("bp_after_pop", a_count, 1);
        check("bp_ready_again", a_in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_third_in", a_count, 1);
        drain();

        out_ready = 1'b0;
        send(32'h00400213, 64'h4000);
        send(32'h00500293, 64'h4004);
        check("fl_count_before", a_count, 2);
        in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 64'h4008;
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", a_count, 0);
        check("fl_valid", a_out_valid, 0);
        repeat (3) step();
        check("fl_dropped", a_count, 0);

        out_ready = 1'b0;
        send(32'h00700393, 64'h5000);
        send(32'h00800413, 64'h5004);
        check("rs_count_before", a_count, 2);
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00900493;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rs_count", a_count, 0);
        check("rs_valid", a_out_valid, 0);
        check("rs_in_ready", a_in_ready, 1);
        check("rs_pc", b_out_pc, 0);
        out_ready = 1'b1;
        repeat (3) step();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_FP, default 0, enable for FP/AMO/fused opcodes (LOAD_FP, STORE_FP, MADD, MSUB, NMSUB, NMADD, OP_FP, AMO).
REQ-003 SHALL have parameter DEPTH, default 2, output queue entries; legal values are powers of two from 2 to 8.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  instruction offered.
REQ-008 in_ready  out  1  stage can accept.
REQ-009 in_instr  in  32  raw instruction word.
REQ-010 in_pc  in  XLEN  instruction address.
REQ-011 flush  in  1  discard all queued and offered instructions.
REQ-012 out_valid  out  1  head entry valid.
REQ-013 out_ready  in  1  consumer accepts head.
REQ-014 out_pc, out_instr  out  XLEN / 32  head address and raw word.
REQ-015 out_op  out  opcode_map  one-hot opcode class (21 flags, same fields as the base opcode map).
REQ-016 out_rd, out_rs1, out_rs2  out  5 each  register indices.
REQ-017 out_funct3, out_funct7  out  3 / 7  function fields.
REQ-018 out_imm  out  XLEN  sign-extended immediate.
REQ-019 out_illegal  out  1  head is an illegal encoding.
REQ-020 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-021 An instruction SHALL be accepted on a cycle with in_valid & in_ready & !flush; it is decoded combinationally and written into the queue tail at that edge.
REQ-022 Latency SHALL be 1 cycle: an instruction accepted into an empty queue SHALL appear with out_valid=1 on the next cycle.
REQ-023 in_ready SHALL be (count < DEPTH) & !flush, with no same-cycle bypass when the queue is full.
REQ-024 The head SHALL be popped on out_valid & out_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 Output order SHALL equal acceptance order; payload SHALL stay stable while out_valid=1 & out_ready=0.
REQ-026 Opcode classes SHALL be decoded from in_instr[6:2] per the RISC-V base opcode map; at most one out_op bit SHALL be set.
REQ-027 Immediate selection:
- I-type for LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM, MISC_MEM, LOAD_FP.
- S-type for STORE, STORE_FP.
- B-type for BRANCH, with bit 0 = 0.
- U-type for LUI, AUIPC, as instr[31:12]<<12.
- J-type for JAL, with bit 0 = 0.
- 0 for all other classes.
REQ-028 All immediates SHALL be sign-extended from instr[31] to XLEN.
REQ-029 An encoding SHALL be illegal, with out_illegal=1, out_op=0 and out_imm=0, when any of these holds:
- instr[1:0] != 2'b11;
- instr[6:2] maps to no class;
- the class is OP_IMM_32 or OP_32 and XLEN=32;
- the class is an FP/AMO class and EN_FP=0.
REQ-030 Illegal instructions SHALL still be queued and delivered in order; they SHALL NOT stall the stage.
REQ-031 With flush=1, count SHALL be 0 and out_valid SHALL be 0 on the next cycle; any in_valid presented in the flush cycle SHALL be dropped.
REQ-032 Flush and a pop in the same cycle SHALL behave as flush alone.
REQ-033 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-034 On rst=1 at a clock edge: count=0, out_valid=0, pointers=0; all payload outputs SHALL read 0.
REQ-035 Reset SHALL take priority over flush, push and pop; instructions in flight during reset are discarded.
REQ-036 in_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-037 XLEN=32: push 0xFFF00093 into an empty queue with out_ready=1 -> next cycle out_valid=1, OP_IMM, rd=1, rs1=0, imm=0xFFFFFFFF.
REQ-038 Push 0x0080006F (jal x0,8) -> JAL, imm=8; with XLEN=64, 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF.
REQ-039 DEPTH=2, out_ready=0, offer 3 instructions back to back -> in_ready=0 after 2 accepts, count=2; with out_ready then 1 -> delivery in order, third accepted after the first pop.
REQ-040 Push 0x00000000, then 0x0000001B -> both out_illegal=1 at XLEN=32; at XLEN=64, 0x0000001B gives OP_IMM_32 with out_illegal=0.
REQ-041 count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, offered word not delivered.
REQ-042 rst=1 with count=2 -> next cycle count=0, out_valid=0, in_ready=1.
